// File: rtl/placar_pkg.sv
// Shared definitions for the score register stage: widths, limits, FSM
// states and the point values of the three buttons.
package placar_pkg;

  localparam int SCORE_W           = 7;
  localparam int MAX_SCORE_DEFAULT = 99;

  localparam logic [1:0] PTS1 = 2'd1;
  localparam logic [1:0] PTS2 = 2'd2;
  localparam logic [1:0] PTS3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    WAIT_SOLTAR
  } estado_t;

  // Highest pressed button wins when several are seen together.
  function automatic logic [1:0] prioridadePontos(input logic [2:0] niveis);
    if (niveis[2])      return PTS3;
    else if (niveis[1]) return PTS2;
    else                return PTS1;
  endfunction

endpackage

// File: rtl/placar_registro_pontos_debounce.sv
// debounce_btn: two-flop synchroniser followed by a stability counter.
// raw_n is active-low; level is the clean active-high button state.
module debounce_btn #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_nivel;
  logic [CW-1:0] r_cont;

  // Synchronise, then accept a new level only after it has been stable long enough.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_nivel <= 1'b0;
      r_cont  <= '0;
    end else begin
      r_sync1 <= ~raw_n;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_nivel) begin
        r_cont <= '0;
      end else if (r_cont == LIMITE) begin
        r_nivel <= ~r_nivel;
        r_cont  <= '0;
      end else begin
        r_cont <= r_cont + 1'b1;
      end
    end
  end

  assign level = r_nivel;

endmodule

// File: rtl/placar_registro_pontos.sv
// placar_registro_pontos: per-team score registers driven by the debounced
// point buttons. One scoring event per press, saturating at 0 and MAX_SCORE.
// Optional one-level undo button is compiled in when PLACAR_UNDO_EN is defined.
module placar_registro_pontos
  import placar_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_SCORE       = MAX_SCORE_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         cBotoes,
  input  logic               chaveNP,
  input  logic               chaveTime,
`ifdef PLACAR_UNDO_EN
  input  logic               btnDesfazer,
`endif
  output logic [SCORE_W-1:0] scoreA,
  output logic [SCORE_W-1:0] scoreB,
  output logic [SCORE_W-1:0] scoreSel,
  output logic               pontoAplicado,
  output logic               saturou
);

  localparam logic [7:0] MAX8 = 8'(MAX_SCORE);

  logic [2:0]         w_nivel;
  logic               w_liberado;
  logic [7:0]         w_atual;
  logic [7:0]         w_soma;
  logic [SCORE_W-1:0] w_resultado;
  logic               w_satura;

  estado_t            r_estado;
  logic [1:0]         r_pts;
  logic [SCORE_W-1:0] r_scoreA;
  logic [SCORE_W-1:0] r_scoreB;
  logic               r_pontoAplicado;
  logic               r_saturou;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    debounce_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock (clock),
      .reset (reset),
      .raw_n (cBotoes[i]),
      .level (w_nivel[i])
    );
  end

`ifdef PLACAR_UNDO_EN
  logic               w_desfazer;
  logic               r_histValido;
  logic               r_histTime;
  logic [SCORE_W-1:0] r_histValor;

  debounce_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_desfazer (
    .clock (clock),
    .reset (reset),
    .raw_n (btnDesfazer),
    .level (w_desfazer)
  );

  assign w_liberado = ~(|w_nivel) & ~w_desfazer;
`else
  assign w_liberado = ~(|w_nivel);
`endif

  // Clamped add/subtract of the latched point value against the selected team.
  always_comb begin
    w_atual     = chaveTime ? 8'(r_scoreB) : 8'(r_scoreA);
    w_soma      = w_atual + 8'(r_pts);
    w_resultado = '0;
    w_satura    = 1'b0;
    if (!chaveNP) begin
      if (w_soma > MAX8) begin
        w_resultado = SCORE_W'(MAX_SCORE);
        w_satura    = 1'b1;
      end else begin
        w_resultado = w_soma[SCORE_W-1:0];
      end
    end else begin
      if (8'(r_pts) > w_atual) begin
        w_resultado = '0;
        w_satura    = 1'b1;
      end else begin
        w_resultado = SCORE_W'(w_atual - 8'(r_pts));
      end
    end
  end

  // Press/apply/release sequencer owning the score registers and the pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado        <= IDLE;
      r_pts           <= '0;
      r_scoreA        <= '0;
      r_scoreB        <= '0;
      r_pontoAplicado <= 1'b0;
      r_saturou       <= 1'b0;
`ifdef PLACAR_UNDO_EN
      r_histValido    <= 1'b0;
      r_histTime      <= 1'b0;
      r_histValor     <= '0;
`endif
    end else begin
      r_pontoAplicado <= 1'b0;
      r_saturou       <= 1'b0;
      case (r_estado)
        IDLE: begin
          if (|w_nivel) begin
            r_pts    <= prioridadePontos(w_nivel);
            r_estado <= APPLY;
          end
`ifdef PLACAR_UNDO_EN
          else if (w_desfazer) begin
            if (r_histValido) begin
              if (r_histTime) r_scoreB <= r_histValor;
              else            r_scoreA <= r_histValor;
              r_histValido    <= 1'b0;
              r_pontoAplicado <= 1'b1;
            end
            r_estado <= WAIT_SOLTAR;
          end
`endif
        end
        APPLY: begin
          if (chaveTime) r_scoreB <= w_resultado;
          else           r_scoreA <= w_resultado;
`ifdef PLACAR_UNDO_EN
          r_histValido <= 1'b1;
          r_histTime   <= chaveTime;
          r_histValor  <= chaveTime ? r_scoreB : r_scoreA;
`endif
          r_pontoAplicado <= 1'b1;
          r_saturou       <= w_satura;
          r_estado        <= WAIT_SOLTAR;
        end
        WAIT_SOLTAR: begin
          if (w_liberado) r_estado <= IDLE;
        end
        default: r_estado <= IDLE;
      endcase
    end
  end

  assign scoreA        = r_scoreA;
  assign scoreB        = r_scoreB;
  assign scoreSel      = chaveTime ? r_scoreB : r_scoreA;
  assign pontoAplicado = r_pontoAplicado;
  assign saturou       = r_saturou;

endmodule
